// File: rtl/memory_dp_pipe_pkg.sv
// rtl/memory_dp_pipe_pkg.sv - shared types, limits and byte-merge helper for memory_dp_pipe
package memory_dp_pipe_pkg;

  typedef enum logic {INIT, READY} state_t;

  localparam int RD_LATENCY_MAX = 4;
  // Widest word the merge helper handles; callers size-cast into and out of it.
  localparam int MERGE_W_MAX    = 128;
  localparam int MERGE_BE_MAX   = MERGE_W_MAX / 8;

  function automatic logic [MERGE_W_MAX-1:0] merge_be(
    input logic [MERGE_W_MAX-1:0]  old_word,
    input logic [MERGE_W_MAX-1:0]  new_word,
    input logic [MERGE_BE_MAX-1:0] be
  );
    logic [MERGE_W_MAX-1:0] merged;
    for (int i = 0; i < MERGE_BE_MAX; i++)
      merged[i*8 +: 8] = be[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
    return merged;
  endfunction

endpackage

// File: rtl/memory_dp_pipe_if.sv
// rtl/memory_dp_pipe_if.sv - one RAM port: request, write data and read response
// par_err exists only when MEMORY_DP_PIPE_PARITY_EN is defined.
interface memory_dp_pipe_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic                  enable;
  logic                  wr_en;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W/8-1:0]   wr_be;
  logic [DATA_W-1:0]     write_data;
  logic                  rd_valid;
  logic [DATA_W-1:0]     read_data;
`ifdef MEMORY_DP_PIPE_PARITY_EN
  logic                  par_err;

  modport master (output enable, wr_en, addr, wr_be, write_data,
                  input  rd_valid, read_data, par_err);
  modport slave  (input  enable, wr_en, addr, wr_be, write_data,
                  output rd_valid, read_data, par_err);
`else
  modport master (output enable, wr_en, addr, wr_be, write_data,
                  input  rd_valid, read_data);
  modport slave  (input  enable, wr_en, addr, wr_be, write_data,
                  output rd_valid, read_data);
`endif
endinterface

// File: rtl/memory_dp_rd_pipe.sv
// rtl/memory_dp_rd_pipe.sv - RD_LATENCY-stage read response delay line, one per port
// Carries a parity error flag when MEMORY_DP_PIPE_PARITY_EN is defined.
module memory_dp_rd_pipe #(
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
`ifdef MEMORY_DP_PIPE_PARITY_EN
  input  logic              in_par_err,
  output logic              par_err,
`endif
  output logic              rd_valid,
  output logic [DATA_W-1:0] read_data
);
  logic [RD_LATENCY-1:0] v;
  logic [DATA_W-1:0]     d [RD_LATENCY];
`ifdef MEMORY_DP_PIPE_PARITY_EN
  logic [RD_LATENCY-1:0] pe;
`endif

  // Data stages only load behind a valid, so the output holds between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < RD_LATENCY; i++) d[i] <= '0;
`ifdef MEMORY_DP_PIPE_PARITY_EN
      pe <= '0;
`endif
    end else begin
      v[0] <= in_valid;
      if (in_valid) d[0] <= in_data;
`ifdef MEMORY_DP_PIPE_PARITY_EN
      pe[0] <= in_valid & in_par_err;
`endif
      for (int i = 1; i < RD_LATENCY; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) d[i] <= d[i-1];
`ifdef MEMORY_DP_PIPE_PARITY_EN
        pe[i] <= pe[i-1];
`endif
      end
    end
  end

  assign rd_valid  = v[RD_LATENCY-1];
  assign read_data = d[RD_LATENCY-1];
`ifdef MEMORY_DP_PIPE_PARITY_EN
  assign par_err   = pe[RD_LATENCY-1];
`endif

endmodule

// File: rtl/memory_dp_pipe.sv
// rtl/memory_dp_pipe.sv - true dual-port RAM: clear FSM, byte enables, collision merge, piped reads
// Optional even-parity storage and checking via MEMORY_DP_PIPE_PARITY_EN.
module memory_dp_pipe
  import memory_dp_pipe_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int READ_FIRST = 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            init_done,
  output logic            collision,
  memory_dp_pipe_if.slave port_a,
  memory_dp_pipe_if.slave port_b
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BE_W   = DATA_W / 8;
`ifdef MEMORY_DP_PIPE_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  if (DATA_W % 8 != 0 || DATA_W > MERGE_W_MAX) begin : g_bad_data_w
    $error("memory_dp_pipe: DATA_W must be a multiple of 8 and fit the merge helper");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
    $error("memory_dp_pipe: RD_LATENCY out of range");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("memory_dp_pipe: DEPTH must be at least 2");
  end

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_word,
                                              input logic [DATA_W-1:0] new_word,
                                              input logic [BE_W-1:0]   be);
    return DATA_W'(merge_be(MERGE_W_MAX'(old_word), MERGE_W_MAX'(new_word), MERGE_BE_MAX'(be)));
  endfunction

  function automatic logic [WORD_W-1:0] pack(input logic [DATA_W-1:0] w);
`ifdef MEMORY_DP_PIPE_PARITY_EN
    return {^w, w};
`else
    return w;
`endif
  endfunction

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic [WORD_W-1:0] mem [DEPTH];

  logic              ready, a_in, b_in, a_wr, b_wr, a_rd, b_rd, same_wr;
  logic [ADDR_W-1:0] a_idx, b_idx;
  logic [DATA_W-1:0] a_old, b_old, a_base, a_new, b_new, a_rword, b_rword;
`ifdef MEMORY_DP_PIPE_PARITY_EN
  logic              a_rpar_err, b_rpar_err;
`endif

  assign ready   = (state == READY);
  assign a_in    = 32'(port_a.addr) < DEPTH;
  assign b_in    = 32'(port_b.addr) < DEPTH;
  assign a_wr    = ready & port_a.enable & port_a.wr_en & a_in;
  assign b_wr    = ready & port_b.enable & port_b.wr_en & b_in;
  assign a_rd    = ready & port_a.enable & ~port_a.wr_en;
  assign b_rd    = ready & port_b.enable & ~port_b.wr_en;
  assign same_wr = a_wr & b_wr & (port_a.addr == port_b.addr);
  assign a_idx   = a_in ? port_a.addr : '0;
  assign b_idx   = b_in ? port_b.addr : '0;
  assign a_old   = mem[a_idx][DATA_W-1:0];
  assign b_old   = mem[b_idx][DATA_W-1:0];

  // On a same-address double write B is applied first so A's enabled bytes win.
  assign b_new   = merge(b_old, port_b.write_data, port_b.wr_be);
  assign a_base  = same_wr ? b_new : a_old;
  assign a_new   = merge(a_base, port_a.write_data, port_a.wr_be);

  always_comb begin
    a_rword = a_old;
    b_rword = b_old;
`ifdef MEMORY_DP_PIPE_PARITY_EN
    a_rpar_err = mem[a_idx][DATA_W] != ^a_old;
    b_rpar_err = mem[b_idx][DATA_W] != ^b_old;
`endif
    if (READ_FIRST == 0 && b_wr && port_b.addr == port_a.addr) begin
      a_rword = b_new;
`ifdef MEMORY_DP_PIPE_PARITY_EN
      a_rpar_err = 1'b0;
`endif
    end
    if (READ_FIRST == 0 && a_wr && port_a.addr == port_b.addr) begin
      b_rword = a_new;
`ifdef MEMORY_DP_PIPE_PARITY_EN
      b_rpar_err = 1'b0;
`endif
    end
    if (!a_in) begin
      a_rword = '0;
`ifdef MEMORY_DP_PIPE_PARITY_EN
      a_rpar_err = 1'b0;
`endif
    end
    if (!b_in) begin
      b_rword = '0;
`ifdef MEMORY_DP_PIPE_PARITY_EN
      b_rpar_err = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!ready) begin
        mem[clr_addr] <= '0;
      end else begin
        if (a_wr) mem[a_idx] <= pack(a_new);
        if (b_wr && !same_wr) mem[b_idx] <= pack(b_new);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      clr_addr  <= '0;
      init_done <= 1'b0;
      collision <= 1'b0;
    end else begin
      collision <= same_wr;
      case (state)
        INIT: begin
          clr_addr <= clr_addr + ADDR_W'(1);
          if (clr_addr == ADDR_W'(DEPTH - 1)) begin
            state     <= READY;
            init_done <= 1'b1;
          end
        end
        default: state <= READY;
      endcase
    end
  end

  memory_dp_rd_pipe #(.DATA_W(DATA_W), .RD_LATENCY(RD_LATENCY)) u_rd_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_rd),
    .in_data   (a_rword),
`ifdef MEMORY_DP_PIPE_PARITY_EN
    .in_par_err(a_rpar_err),
    .par_err   (port_a.par_err),
`endif
    .rd_valid  (port_a.rd_valid),
    .read_data (port_a.read_data)
  );

  memory_dp_rd_pipe #(.DATA_W(DATA_W), .RD_LATENCY(RD_LATENCY)) u_rd_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_rd),
    .in_data   (b_rword),
`ifdef MEMORY_DP_PIPE_PARITY_EN
    .in_par_err(b_rpar_err),
    .par_err   (port_b.par_err),
`endif
    .rd_valid  (port_b.rd_valid),
    .read_data (port_b.read_data)
  );

endmodule

// File: tb/tb_memory_dp_pipe.sv
// tb/tb_memory_dp_pipe.sv - directed bench: u0 DEPTH16/lat3/read-first, u1 DEPTH12/lat1/write-first
module tb_memory_dp_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic done0, col0, done1, col1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  memory_dp_pipe_if #(.ADDR_W(4), .DATA_W(32)) a0 ();
  memory_dp_pipe_if #(.ADDR_W(4), .DATA_W(32)) b0 ();
  memory_dp_pipe_if #(.ADDR_W(4), .DATA_W(32)) a1 ();
  memory_dp_pipe_if #(.ADDR_W(4), .DATA_W(32)) b1 ();

  memory_dp_pipe #(.DEPTH(16), .DATA_W(32), .RD_LATENCY(3), .READ_FIRST(1)) u0 (
    .clk(clk), .rst(rst), .init_done(done0), .collision(col0), .port_a(a0), .port_b(b0));
  memory_dp_pipe #(.DEPTH(12), .DATA_W(32), .RD_LATENCY(1), .READ_FIRST(0)) u1 (
    .clk(clk), .rst(rst), .init_done(done1), .collision(col1), .port_a(a1), .port_b(b1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int d, input int p, input logic en, input logic we,
                          input logic [3:0] ad, input logic [3:0] be, input logic [31:0] wd);
    case (d * 2 + p)
      0: begin a0.enable = en; a0.wr_en = we; a0.addr = ad; a0.wr_be = be; a0.write_data = wd; end
      1: begin b0.enable = en; b0.wr_en = we; b0.addr = ad; b0.wr_be = be; b0.write_data = wd; end
      2: begin a1.enable = en; a1.wr_en = we; a1.addr = ad; a1.wr_be = be; a1.write_data = wd; end
      default: begin b1.enable = en; b1.wr_en = we; b1.addr = ad; b1.wr_be = be; b1.write_data = wd; end
    endcase
  endtask

  task automatic idle();
    for (int i = 0; i < 4; i++) set_port(i / 2, i % 2, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
  endtask

  function automatic logic get_valid(input int d, input int p);
    case (d * 2 + p)
      0: return a0.rd_valid;
      1: return b0.rd_valid;
      2: return a1.rd_valid;
      default: return b1.rd_valid;
    endcase
  endfunction

  function automatic logic [31:0] get_data(input int d, input int p);
    case (d * 2 + p)
      0: return a0.read_data;
      1: return b0.read_data;
      2: return a1.read_data;
      default: return b1.read_data;
    endcase
  endfunction

  function automatic logic get_pe(input int d, input int p);
`ifdef MEMORY_DP_PIPE_PARITY_EN
    case (d * 2 + p)
      0: return a0.par_err;
      1: return b0.par_err;
      2: return a1.par_err;
      default: return b1.par_err;
    endcase
`else
    return (d < 0 && p < 0);
`endif
  endfunction

  task automatic do_write(input int d, input int p, input logic [3:0] ad,
                          input logic [3:0] be, input logic [31:0] wd);
    set_port(d, p, 1'b1, 1'b1, ad, be, wd);
    tick();
    idle();
  endtask

  // lat = L means rd_valid seen after accept edge N+L-1; -1 when it never came.
  task automatic do_read(input int d, input int p, input logic [3:0] ad,
                         output logic [31:0] data, output int lat, output logic pe);
    set_port(d, p, 1'b1, 1'b0, ad, 4'd0, 32'd0);
    tick();
    idle();
    lat  = -1;
    data = 32'hxxxx_xxxx;
    pe   = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (get_valid(d, p)) begin
        lat  = k;
        data = get_data(d, p);
        pe   = get_pe(d, p);
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; int lat; logic pe;
    idle();
    rst = 1'b1;
    tick(); tick();
    n_cmp++; if (done0 !== 1'b0 || col0 !== 1'b0)
      begin n_fail++; $display("FAIL reset_flags: init_done=%b collision=%b, want 0 0", done0, col0); end
    n_cmp++; if (a0.rd_valid !== 1'b0 || a0.read_data !== 32'd0)
      begin n_fail++; $display("FAIL reset_read: rd_valid=%b read_data=%h, want 0 0", a0.rd_valid, a0.read_data); end
    rst = 1'b0;
    set_port(0, 0, 1'b1, 1'b1, 4'd1, 4'hF, 32'hFFFF_FFFF);
    for (int c = 1; c <= 16; c++) begin
      tick();
      n_cmp++; if (done0 !== (c == 16))
        begin n_fail++; $display("FAIL init_done_c%0d: got %b want %b", c, done0, (c == 16)); end
    end
    idle();
    for (int i = 0; i < 16; i++) begin
      do_read(0, 0, 4'(i), d, lat, pe);
      n_cmp++; if (d !== 32'd0 || lat !== 3)
        begin n_fail++; $display("FAIL clear_read_%0d: data=%h lat=%0d want 0 3", i, d, lat); end
    end
    do_write(0, 0, 4'd10, 4'hF, 32'h1234_5678);
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 7; c++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      n_cmp++; if (done0 !== (c == 16))
        begin n_fail++; $display("FAIL restart_done_c%0d: got %b want %b", c, done0, (c == 16)); end
    end
    do_read(0, 0, 4'd10, d, lat, pe);
    n_cmp++; if (d !== 32'd0)
      begin n_fail++; $display("FAIL restart_clear: data=%h want 0", d); end
  endtask

  task automatic test_basic();
    logic [31:0] d; int lat; logic pe;
    set_port(0, 0, 1'b1, 1'b1, 4'd3, 4'hF, 32'hDEAD_BEEF);
    set_port(0, 1, 1'b1, 1'b1, 4'd5, 4'h1, 32'h0000_00AA);
    tick();
    idle();
    do_read(0, 0, 4'd3, d, lat, pe);
    n_cmp++; if (d !== 32'hDEAD_BEEF || lat !== 3)
      begin n_fail++; $display("FAIL basic_a3: data=%h lat=%0d want deadbeef 3", d, lat); end
    tick();
    n_cmp++; if (a0.rd_valid !== 1'b0)
      begin n_fail++; $display("FAIL valid_one_cycle: rd_valid=%b want 0", a0.rd_valid); end
    do_read(0, 1, 4'd5, d, lat, pe);
    n_cmp++; if (d !== 32'h0000_00AA || lat !== 3)
      begin n_fail++; $display("FAIL basic_b5: data=%h lat=%0d want 000000aa 3", d, lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'hDEAD_BEEF; exp_d[1] = 32'h0000_00AA; exp_d[2] = 32'hDEAD_BEEF;
    set_port(0, 0, 1'b1, 1'b0, 4'd3, 4'd0, 32'd0); tick();
    set_port(0, 0, 1'b1, 1'b0, 4'd5, 4'd0, 32'd0); tick();
    n_cmp++; if (a0.rd_valid !== 1'b0)
      begin n_fail++; $display("FAIL b2b_early: rd_valid=%b want 0", a0.rd_valid); end
    set_port(0, 0, 1'b1, 1'b0, 4'd3, 4'd0, 32'd0); tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (a0.rd_valid !== 1'b1 || a0.read_data !== exp_d[k])
        begin n_fail++; $display("FAIL b2b_%0d: valid=%b data=%h want 1 %h", k, a0.rd_valid, a0.read_data, exp_d[k]); end
      tick();
    end
    n_cmp++; if (a0.rd_valid !== 1'b0 || a0.read_data !== 32'hDEAD_BEEF)
      begin n_fail++; $display("FAIL b2b_hold: valid=%b data=%h want 0 deadbeef", a0.rd_valid, a0.read_data); end
  endtask

  task automatic test_byte_enable();
    logic [31:0] d; int lat; logic pe;
    do_write(0, 0, 4'd2, 4'hF, 32'h1122_3344);
    do_write(0, 0, 4'd2, 4'b0011, 32'hAABB_CCDD);
    do_read(0, 0, 4'd2, d, lat, pe);
    n_cmp++; if (d !== 32'h1122_CCDD)
      begin n_fail++; $display("FAIL be_partial: data=%h want 1122ccdd", d); end
    do_write(0, 1, 4'd2, 4'b0000, 32'hFFFF_FFFF);
    do_read(0, 1, 4'd2, d, lat, pe);
    n_cmp++; if (d !== 32'h1122_CCDD)
      begin n_fail++; $display("FAIL be_zero: data=%h want 1122ccdd", d); end
  endtask

  task automatic test_collision();
    logic [31:0] d; int lat; logic pe;
    set_port(0, 0, 1'b1, 1'b1, 4'd9, 4'hF, 32'h1111_1111);
    set_port(0, 1, 1'b1, 1'b1, 4'd9, 4'hF, 32'h2222_2222);
    tick(); idle();
    n_cmp++; if (col0 !== 1'b1)
      begin n_fail++; $display("FAIL collision_pulse: got %b want 1", col0); end
    tick();
    n_cmp++; if (col0 !== 1'b0)
      begin n_fail++; $display("FAIL collision_clear: got %b want 0", col0); end
    do_read(0, 1, 4'd9, d, lat, pe);
    n_cmp++; if (d !== 32'h1111_1111)
      begin n_fail++; $display("FAIL collision_a_wins: data=%h want 11111111", d); end
    set_port(0, 0, 1'b1, 1'b1, 4'd9, 4'b0001, 32'h1111_1111);
    set_port(0, 1, 1'b1, 1'b1, 4'd9, 4'hF, 32'h2222_2222);
    tick(); idle();
    n_cmp++; if (col0 !== 1'b1)
      begin n_fail++; $display("FAIL collision_pulse2: got %b want 1", col0); end
    do_read(0, 0, 4'd9, d, lat, pe);
    n_cmp++; if (d !== 32'h2222_2211)
      begin n_fail++; $display("FAIL collision_merge: data=%h want 22222211", d); end
    set_port(0, 0, 1'b1, 1'b1, 4'd9, 4'hF, 32'h3333_3333);
    set_port(0, 1, 1'b1, 1'b1, 4'd8, 4'hF, 32'h4444_4444);
    tick(); idle();
    n_cmp++; if (col0 !== 1'b0)
      begin n_fail++; $display("FAIL collision_diff_addr: got %b want 0", col0); end
  endtask

  task automatic test_read_write();
    logic [31:0] d; int lat; logic pe;
    do_write(0, 0, 4'd4, 4'hF, 32'h5);
    set_port(0, 0, 1'b1, 1'b1, 4'd4, 4'hF, 32'h9);
    set_port(0, 1, 1'b1, 1'b0, 4'd4, 4'd0, 32'd0);
    tick(); idle();
    tick(); tick();
    n_cmp++; if (b0.rd_valid !== 1'b1 || b0.read_data !== 32'h5)
      begin n_fail++; $display("FAIL read_first: valid=%b data=%h want 1 00000005", b0.rd_valid, b0.read_data); end
    do_read(0, 0, 4'd4, d, lat, pe);
    n_cmp++; if (d !== 32'h9)
      begin n_fail++; $display("FAIL read_first_after: data=%h want 00000009", d); end
    do_write(1, 0, 4'd4, 4'hF, 32'h5);
    set_port(1, 0, 1'b1, 1'b1, 4'd4, 4'hF, 32'h9);
    set_port(1, 1, 1'b1, 1'b0, 4'd4, 4'd0, 32'd0);
    tick(); idle();
    n_cmp++; if (b1.rd_valid !== 1'b1 || b1.read_data !== 32'h9)
      begin n_fail++; $display("FAIL write_first: valid=%b data=%h want 1 00000009", b1.rd_valid, b1.read_data); end
    set_port(1, 0, 1'b1, 1'b1, 4'd4, 4'b0001, 32'hAABB_CC77);
    set_port(1, 1, 1'b1, 1'b0, 4'd4, 4'd0, 32'd0);
    tick(); idle();
    n_cmp++; if (b1.rd_valid !== 1'b1 || b1.read_data !== 32'h77)
      begin n_fail++; $display("FAIL write_first_be: valid=%b data=%h want 1 00000077", b1.rd_valid, b1.read_data); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; int lat; logic pe;
    do_write(1, 0, 4'd13, 4'hF, 32'hDEAD_BEEF);
    do_read(1, 1, 4'd13, d, lat, pe);
    n_cmp++; if (d !== 32'd0 || lat !== 1)
      begin n_fail++; $display("FAIL oor_read: data=%h lat=%0d want 0 1", d, lat); end
    do_read(1, 0, 4'd0, d, lat, pe);
    n_cmp++; if (d !== 32'd0)
      begin n_fail++; $display("FAIL oor_no_alias: data=%h want 0", d); end
    set_port(1, 0, 1'b1, 1'b1, 4'd13, 4'hF, 32'h1);
    set_port(1, 1, 1'b1, 1'b1, 4'd13, 4'hF, 32'h2);
    tick(); idle();
    n_cmp++; if (col1 !== 1'b0)
      begin n_fail++; $display("FAIL oor_collision: got %b want 0", col1); end
    do_write(0, 0, 4'd15, 4'hF, 32'hCAFE_F00D);
    do_read(0, 1, 4'd15, d, lat, pe);
    n_cmp++; if (d !== 32'hCAFE_F00D)
      begin n_fail++; $display("FAIL top_addr: data=%h want cafef00d", d); end
  endtask

`ifdef MEMORY_DP_PIPE_PARITY_EN
  task automatic test_parity();
    logic [31:0] d; int lat; logic pe;
    do_read(1, 0, 4'd4, d, lat, pe);
    n_cmp++; if (pe !== 1'b0 || d !== 32'h77)
      begin n_fail++; $display("FAIL parity_clean: par_err=%b data=%h want 0 00000077", pe, d); end
    u1.mem[4][0] = ~u1.mem[4][0];
    do_read(1, 0, 4'd4, d, lat, pe);
    n_cmp++; if (pe !== 1'b1 || lat !== 1 || d !== 32'h76)
      begin n_fail++; $display("FAIL parity_flip: par_err=%b lat=%0d data=%h want 1 1 00000076", pe, lat, d); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle();
    test_reset();
    test_basic();
    test_back_to_back();
    test_byte_enable();
    test_collision();
    test_read_write();
    test_out_of_range();
`ifdef MEMORY_DP_PIPE_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
